// File: rtl/memory_pkg.sv
// ---------------------------------------------------------------------------
// memory_pkg
// Shared definitions for the data memory responder: bus widths, the FSM
// state encoding and the width of the access-latency down-counter.
// ---------------------------------------------------------------------------
package memory_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDR_WIDTH    = 32;

    // LATENCY is limited to 1..15, so a 4-bit counter holds LATENCY-1.
    localparam int COUNTER_WIDTH = 4;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_WAIT = 2'd1;
    localparam logic [1:0] STATE_RESP = 2'd2;

endpackage : memory_pkg

// File: rtl/memory_array.sv
// ---------------------------------------------------------------------------
// memory_array
// Single-port synchronous word RAM with registered (one-cycle) read.
// The read is read-first: a write and a read of the same word in the same
// cycle return the old contents.
//
// Ports:
//   clk           in   clock
//   write_enable  in   write strobe for this cycle
//   index         in   word index (log2(DEPTH) bits)
//   write_data    in   data written when write_enable is high
//   read_data     out  contents of mem[index] as seen at the previous edge
// ---------------------------------------------------------------------------
module memory_array
    import memory_pkg::*;
#(
    parameter int    DEPTH       = 1024,
    parameter string MEMORY_FILE = "",
    localparam int   INDEX_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [DATA_WIDTH-1:0]  write_data,
    output logic [DATA_WIDTH-1:0]  read_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] read_data_q;

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[index] <= write_data;
        end
        read_data_q <= mem[index];
    end

    assign read_data = read_data_q;

endmodule : memory_array

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
// Memory-side responder for the core's data bus. A read or write strobe seen
// in IDLE is latched, the access is performed LATENCY cycles later, and a
// single-cycle response strobe follows. Strobes in WAIT and RESP are ignored
// because the stalled core keeps re-asserting its request.
//
// Ports:
//   clk                   in   clock
//   reset                 in   synchronous active-high reset
//   data_memory_read      in   read request strobe
//   data_memory_write     in   write request strobe (wins over read)
//   data_address          in   byte address, bits [1:0] ignored
//   write_data            in   store data, captured with the request
//   data_memory_response  out  one-cycle completion strobe
//   read_data             out  load result, held until the next read completes
// ---------------------------------------------------------------------------
module data_memory_responder
    import memory_pkg::*;
#(
    parameter int    DEPTH       = 1024,
    parameter int    LATENCY     = 2,
    parameter string MEMORY_FILE = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_memory_read,
    input  logic                  data_memory_write,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  data_memory_response,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int INDEX_WIDTH = $clog2(DEPTH);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_LOAD = COUNTER_WIDTH'(LATENCY - 1);

    logic [1:0]               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic                     response_q, response_d;
    logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
    logic [INDEX_WIDTH-1:0]   index_q, index_d;
    logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
    logic                     op_write_q, op_write_d;

    logic [INDEX_WIDTH-1:0]   address_index;
    logic [INDEX_WIDTH-1:0]   ram_index;
    logic [DATA_WIDTH-1:0]    ram_read_data;
    logic                     ram_write_enable;
    logic                     access_cycle;
    logic                     unused_address_bits;

    // Upper address bits alias; byte offset is ignored.
    assign address_index       = data_address[INDEX_WIDTH+1:2];
    assign unused_address_bits = ^{data_address[ADDR_WIDTH-1:INDEX_WIDTH+2],
                                   data_address[1:0]};

    assign access_cycle = (state_q == STATE_WAIT) && (counter_q == '0);

    // The RAM read is registered, so its address must be presented one
    // cycle before the access cycle. The RAM reads every cycle: in IDLE it
    // looks at the incoming address (covers LATENCY=1, where the access
    // cycle directly follows acceptance), in WAIT at the latched index
    // (covers counter==1 for LATENCY>=2). Either way ram_read_data holds
    // mem[index_q] during the access cycle.
    assign ram_index = (state_q == STATE_IDLE) ? address_index : index_q;

    // Reset in the access cycle must abort the write.
    assign ram_write_enable = access_cycle && op_write_q && !reset;

    memory_array #(
        .DEPTH       (DEPTH),
        .MEMORY_FILE (MEMORY_FILE)
    ) u_memory_array (
        .clk          (clk),
        .write_enable (ram_write_enable),
        .index        (ram_index),
        .write_data   (write_data_q),
        .read_data    (ram_read_data)
    );

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        response_d   = 1'b0;
        read_data_d  = read_data_q;
        index_d      = index_q;
        write_data_d = write_data_q;
        op_write_d   = op_write_q;

        case (state_q)
            STATE_IDLE: begin
                if (data_memory_read || data_memory_write) begin
                    index_d      = address_index;
                    write_data_d = write_data;
                    op_write_d   = data_memory_write;
                    counter_d    = COUNT_LOAD;
                    state_d      = STATE_WAIT;
                end
            end

            STATE_WAIT: begin
                if (counter_q == '0) begin
                    if (!op_write_q) begin
                        read_data_d = ram_read_data;
                    end
                    response_d = 1'b1;
                    state_d    = STATE_RESP;
                end else begin
                    counter_d = counter_q - 1'b1;
                end
            end

            STATE_RESP: begin
                state_d = STATE_IDLE;
            end

            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= STATE_IDLE;
            counter_q   <= '0;
            response_q  <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            response_q  <= response_d;
            read_data_q <= read_data_d;
        end
    end

    // Request payload only matters after acceptance, so it is not reset.
    always_ff @(posedge clk) begin
        index_q      <= index_d;
        write_data_q <= write_data_d;
        op_write_q   <= op_write_d;
    end

    assign data_memory_response = response_q;
    assign read_data            = read_data_q;

endmodule : data_memory_responder

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_address;
    logic [31:0] write_data;
    logic        data_memory_response;
    logic [31:0] read_data;

    data_memory_responder #(
        .DEPTH       (DEPTH),
        .LATENCY     (LAT),
        .MEMORY_FILE ("")
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .data_memory_read     (data_memory_read),
        .data_memory_write    (data_memory_write),
        .data_address         (data_address),
        .write_data           (write_data),
        .data_memory_response (data_memory_response),
        .read_data            (read_data)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // An accepted request at edge e responds after edge e+LAT and the next
    // request can be accepted no earlier than edge e+LAT+2.
    logic [31:0] mmem [int];
    int          edge_no   = 0;
    bit          pending   = 0;
    int          resp_at   = 0;
    int          idle_from = 0;
    bit          p_wr;
    int          p_idx;
    logic [31:0] p_wd;
    logic        exp_resp  = 0;
    logic [31:0] exp_rd    = 0;
    bit          rd_known  = 1;
    bit          chk_en    = 0;

    always @(posedge clk) begin
        edge_no++;
        if (reset) begin
            pending   = 0;
            exp_resp  = 0;
            exp_rd    = 0;
            rd_known  = 1;
            idle_from = edge_no + 1;
        end else begin
            exp_resp = 0;
            if (pending && edge_no == resp_at) begin
                exp_resp = 1;
                pending  = 0;
                if (p_wr) mmem[p_idx] = p_wd;
                else if (mmem.exists(p_idx)) begin
                    exp_rd   = mmem[p_idx];
                    rd_known = 1;
                end else rd_known = 0;
            end
            if (!pending && edge_no >= idle_from && (data_memory_read || data_memory_write)) begin
                pending   = 1;
                p_wr      = data_memory_write;
                p_idx     = int'((data_address >> 2) % DEPTH);
                p_wd      = write_data;
                resp_at   = edge_no + LAT;
                idle_from = edge_no + LAT + 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("response", {31'b0, data_memory_response}, {31'b0, exp_resp});
            if (rd_known) check("read_data", read_data, exp_rd);
        end
    end

    // Drive a request for `hold` cycles, observe `span` cycles; offsets are
    // counted from the cycle the strobe first appears.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, input int span,
                          output int n, output int off0, output int off1,
                          output logic [31:0] rdv);
        n = 0; off0 = -1; off1 = -1; rdv = '0;
        for (int i = 0; i < span; i++) begin
            data_memory_read  = (i < hold) ? rd : 1'b0;
            data_memory_write = (i < hold) ? wr : 1'b0;
            data_address      = a;
            write_data        = wd;
            @(negedge clk);
            if (data_memory_response) begin
                if (n == 0) off0 = i;
                else if (n == 1) off1 = i;
                n++;
                rdv = read_data;
            end
            @(posedge clk); #1;
        end
        data_memory_read  = 1'b0;
        data_memory_write = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] wd);
        int n, o0, o1;
        logic [31:0] r;
        run_op(1'b0, 1'b1, a, wd, 1, LAT + 3, n, o0, o1, r);
    endtask

    logic [31:0] rand_addr [8];

    initial begin
        int n, o0, o1, cnt;
        logic [31:0] r;

        reset = 1'b1;
        data_memory_read = 1'b0; data_memory_write = 1'b0;
        data_address = '0; write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        @(negedge clk);
        check("reset_response", {31'b0, data_memory_response}, 32'd0);
        check("reset_read_data", read_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Known contents for words the directed tests read back.
        write_word(32'h80, 32'h0);
        write_word(32'h20, 32'h12345678);

        // Test 1: write, response at +3, read_data unchanged (0).
        run_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1, 6, n, o0, o1, r);
        check("t1_count", n, 1);
        check("t1_offset", o0, 3);
        check("t1_read_data", r, 32'h0);

        // Test 2: read back, also through byte offset 3.
        run_op(1'b1, 1'b0, 32'h10, 32'h0, 1, 6, n, o0, o1, r);
        check("t2_offset", o0, 3);
        check("t2_data", r, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 32'h13, 32'h0, 1, 6, n, o0, o1, r);
        check("t2_offset_byte3", o0, 3);
        check("t2_data_byte3", r, 32'hDEADBEEF);

        // Test 3: read held 8 cycles -> responses at 3 and 7 only.
        run_op(1'b1, 1'b0, 32'h20, 32'h0, 8, 12, n, o0, o1, r);
        check("t3_count", n, 2);
        check("t3_first", o0, 3);
        check("t3_second", o1, 7);
        check("t3_data", r, 32'h12345678);

        // Test 4: read+write together -> write wins, single response.
        run_op(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1, 6, n, o0, o1, r);
        check("t4_count", n, 1);
        check("t4_read_data_kept", r, 32'h12345678);
        run_op(1'b1, 1'b0, 32'h40, 32'h0, 1, 6, n, o0, o1, r);
        check("t4_readback", r, 32'hA5A5A5A5);

        // Test 5: reset during WAIT aborts the write.
        data_memory_write = 1'b1; data_address = 32'h80; write_data = 32'h11111111;
        @(posedge clk); #1;
        data_memory_write = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (data_memory_response) cnt++;
            @(posedge clk); #1;
        end
        check("t5_no_response", cnt, 0);
        check("t5_read_data_cleared", read_data, 32'h0);
        run_op(1'b1, 1'b0, 32'h80, 32'h0, 1, 6, n, o0, o1, r);
        check("t5_prior_contents", r, 32'h0);

        // Test 6: aliasing modulo DEPTH*4.
        write_word(32'h00001004, 32'hCAFEF00D);
        run_op(1'b1, 1'b0, 32'h00000004, 32'h0, 1, 6, n, o0, o1, r);
        check("t6_alias", r, 32'hCAFEF00D);

        // Randomised traffic over a small word set with aliasing addresses.
        for (int k = 0; k < 8; k++) begin
            rand_addr[k] = 32'h200 + 32'(k * 4);
            write_word(rand_addr[k], $urandom);
        end
        for (int c = 0; c < 400; c++) begin
            int k;
            k = int'($urandom_range(0, 7));
            data_address      = (32'($urandom_range(0, 255)) << 12) | rand_addr[k] |
                                32'($urandom_range(0, 3));
            write_data        = $urandom;
            data_memory_read  = ($urandom_range(0, 2) == 0);
            data_memory_write = ($urandom_range(0, 3) == 0);
            reset             = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        data_memory_read = 1'b0; data_memory_write = 1'b0; reset = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule : tb_data_memory_responder
